// File: rtl/rx_pkt_parser.sv
// Receive-side packet parser feeding QTU_FMB: classifies heartbeat and Q-value packets.
// Optional statistics counters are enabled with the RX_PKT_STATS_EN macro.
module rx_pkt_parser #(
    parameter int                    WORD_WIDTH = 16,
    parameter logic [3:0]            TYPE_HB    = 4'h1,
    parameter logic [3:0]            TYPE_QPKT  = 4'h2,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_last,
    output logic                  rx_ready,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic                  iAmDestination,
    output logic                  en,
    output logic                  HB_Reset
`ifdef RX_PKT_STATS_EN
    ,
    output logic [15:0]           pktAccepted,
    output logic [15:0]           pktDropped,
    output logic [15:0]           pktMalformed
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [3:0] cnt, cnt_next, cnt_inc;
    logic [3:0] exp_len, exp_len_next;
    logic       is_q, is_q_next;
    logic       accept;
    logic [3:0] hdr_type;
    logic       word_end;
    logic       emit_hb, emit_q;

    logic [WORD_WIDTH-1:0] sh_dest, sh_src, sh_hops, sh_qval, sh_energy, sh_hfch;

    assign accept   = rx_valid && rx_ready;
    assign hdr_type = rx_data[WORD_WIDTH-1:WORD_WIDTH-4];
    assign cnt_inc  = cnt + 4'd1;
    assign word_end = (cnt_inc == exp_len);

    // Next-state, counter and emit-event decode.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        exp_len_next = exp_len;
        is_q_next    = is_q;
        emit_hb      = 1'b0;
        emit_q       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((hdr_type == TYPE_HB || hdr_type == TYPE_QPKT) && !rx_last) begin
                        state_next   = COLLECT;
                        cnt_next     = 4'd1;
                        is_q_next    = (hdr_type == TYPE_QPKT);
                        exp_len_next = (hdr_type == TYPE_QPKT) ? 4'd8 : 4'd2;
                    end else if (rx_last) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DISCARD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            COLLECT: begin
                if (accept) begin
                    cnt_next = cnt_inc;
                    if (word_end && rx_last) begin
                        state_next = EMIT;
                        cnt_next   = 4'd0;
                        if (is_q) begin
                            emit_q = (sh_src != myNodeID);
                        end else begin
                            emit_hb = 1'b1;
                        end
                    end else if (word_end) begin
                        state_next = DISCARD;
                        cnt_next   = 4'd0;
                    end else if (rx_last) begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = COLLECT;
                    end
                end else begin
                    state_next = COLLECT;
                end
            end
            DISCARD: begin
                if (accept && rx_last) begin
                    state_next = IDLE;
                end else begin
                    state_next = DISCARD;
                end
            end
            EMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // FSM, shadow capture and registered outputs; f* only change on an accepted Q packet.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            exp_len        <= 4'd0;
            is_q           <= 1'b0;
            rx_ready       <= 1'b1;
            sh_dest        <= '0;
            sh_src         <= '0;
            sh_hops        <= '0;
            sh_qval        <= '0;
            sh_energy      <= '0;
            sh_hfch        <= '0;
            fSourceID      <= '0;
            fSourceHops    <= '0;
            fQValue        <= '0;
            fEnergyLeft    <= '0;
            fHopsFromCH    <= '0;
            fChosenCH      <= '0;
            iAmDestination <= 1'b0;
            en             <= 1'b0;
            HB_Reset       <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            exp_len  <= exp_len_next;
            is_q     <= is_q_next;
            rx_ready <= (state_next != EMIT);
            en       <= emit_q;
            HB_Reset <= emit_hb;
            if (state == COLLECT && accept) begin
                case (cnt)
                    4'd1:    sh_dest   <= rx_data;
                    4'd2:    sh_src    <= rx_data;
                    4'd3:    sh_hops   <= rx_data;
                    4'd4:    sh_qval   <= rx_data;
                    4'd5:    sh_energy <= rx_data;
                    4'd6:    sh_hfch   <= rx_data;
                    default: sh_dest   <= sh_dest;
                endcase
            end
            // The chosenCH word is the last handshake, so it is taken straight from the bus.
            if (emit_q) begin
                fSourceID      <= sh_src;
                fSourceHops    <= sh_hops;
                fQValue        <= sh_qval;
                fEnergyLeft    <= sh_energy;
                fHopsFromCH    <= sh_hfch;
                fChosenCH      <= rx_data;
                iAmDestination <= (sh_dest == myNodeID) && (sh_dest != BCAST_ID);
            end
        end
    end

`ifdef RX_PKT_STATS_EN
    logic ev_drop, ev_mal;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Classify the handshake into drop / malformed events for the counters.
    always_comb begin
        ev_drop = 1'b0;
        ev_mal  = 1'b0;
        if (accept && state == IDLE) begin
            ev_drop = !(hdr_type == TYPE_HB || hdr_type == TYPE_QPKT);
            ev_mal  = (hdr_type == TYPE_HB || hdr_type == TYPE_QPKT) && rx_last;
        end else if (accept && state == COLLECT) begin
            ev_drop = word_end && rx_last && is_q && (sh_src == myNodeID);
            ev_mal  = word_end != rx_last;
        end else begin
            ev_drop = 1'b0;
            ev_mal  = 1'b0;
        end
    end

    // Saturating packet statistics.
    always_ff @(posedge clk) begin
        if (nrst) begin
            pktAccepted  <= 16'd0;
            pktDropped   <= 16'd0;
            pktMalformed <= 16'd0;
        end else begin
            if (emit_q || emit_hb) begin
                pktAccepted <= sat_inc(pktAccepted);
            end
            if (ev_drop) begin
                pktDropped <= sat_inc(pktDropped);
            end
            if (ev_mal) begin
                pktMalformed <= sat_inc(pktMalformed);
            end
        end
    end
`endif

endmodule

// File: doc/rx_pkt_parser.md
Name: rx_pkt_parser

Overview:
- Upstream stage of the Q-table update / find-max-best (QTU_FMB) block.
- Receives the decoded packet word stream from the radio receive buffer, one 16-bit word per handshake.
- Classifies each packet: heartbeat packets issue an HB_Reset pulse; Q-value packets have their fields latched and an en pulse issued to QTU_FMB; all other packets are dropped.
- Drives the fSourceID..fChosenCH, iAmDestination, en and HB_Reset inputs of QTU_FMB directly.

Parameters:
- WORD_WIDTH, 16, data word and field width.
- TYPE_HB, 4'h1, header type code for a heartbeat packet.
- TYPE_QPKT, 4'h2, header type code for a Q-value/neighbour packet.
- BCAST_ID, 16'hFFFF, broadcast destination ID.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nrst  in  1  synchronous, active-high reset. The codebase port name is kept; polarity is high.
- myNodeID  in  16  this node's ID; quasi-static.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_data  in  16  packet word.
- rx_last  in  1  marks the final word of the packet; qualified by rx_valid.
- rx_ready  out  1  parser accepts a word when rx_valid && rx_ready.
- fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH  out  16 each  latched packet fields.
- iAmDestination  out  1  the destination field equals myNodeID.
- en  out  1  one-cycle pulse: a new Q packet is presented.
- HB_Reset  out  1  one-cycle pulse: a heartbeat was received.

Behaviour:
- Reset (nrst=1 at a clk edge):
  - All f* outputs go to 0; iAmDestination, en and HB_Reset go to 0; rx_ready goes to 1; the FSM goes to IDLE; the word counter goes to 0.
  - Reset mid-packet abandons the packet. The remaining words are treated as a new packet, with the first word taken as a header.
- Packet format (word index in brackets):
  - [0] header: [15:12] type, [11:0] reserved.
  - HB packet: [1] source ID. Exactly 2 words.
  - Q packet, exactly 8 words: [1] destID, [2] srcID, [3] srcHops, [4] QValue, [5] energyLeft, [6] hopsFromCH, [7] chosenCH.
- States:
  - IDLE: wait for the header word.
    - Type TYPE_HB goes to COLLECT with an expected length of 2.
    - Type TYPE_QPKT goes to COLLECT with an expected length of 8.
    - Any other type goes to DISCARD, or stays in IDLE if the header word has rx_last set.
  - COLLECT: each accepted word is stored into a shadow register by index; the counter increments.
    - rx_last before the expected count is a short packet: drop it and return to IDLE.
    - The expected count reached without rx_last is a long packet: drop it and go to DISCARD.
    - The expected count reached with rx_last goes to EMIT.
  - DISCARD: accept and ignore words until rx_last is accepted, then go to IDLE.
  - EMIT, lasting one cycle with rx_ready=0:
    - HB packet: pulse HB_Reset. The f* outputs are unchanged.
    - Q packet with srcID == myNodeID (own echo): drop it. No en pulse; outputs unchanged.
    - Q packet otherwise: copy the shadow registers to the f* outputs, set iAmDestination = (destID == myNodeID), and pulse en. A destID of BCAST_ID gives iAmDestination=0.
    - Always return to IDLE.
- Outputs are updated only in EMIT, so the f* outputs stay stable between en pulses.
- Latency: en/HB_Reset asserts in the cycle after the last-word handshake (registered), and lasts exactly 1 cycle.
- rx_ready is 0 only in EMIT, so back-to-back packets have a minimum gap of 1 cycle.
- rx_valid=0 in any state: hold the state and counter.
- Header word with rx_last=1: drop the packet. No pulse.

Optional Feature:
- Macro: RX_PKT_STATS_EN.
- When defined, add outputs pktAccepted (16), pktDropped (16) and pktMalformed (16).
  - pktAccepted increments on every en or HB_Reset pulse.
  - pktDropped increments on an unknown type or an own echo.
  - pktMalformed increments on a short or long packet.
  - All three are saturating counters, cleared by nrst.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then HB packet {16'h1000, 16'd25} -> HB_Reset high for exactly 1 cycle, one cycle after the last word; en stays 0; f* outputs stay 0.
- Q packet from myNodeID=16'd7: {16'h2000, 16'd7, 16'd65, 16'd2, 16'h0c00, 16'h3333, 16'd2, 16'd25} -> one en pulse; fSourceID=65, fQValue=16'h0c00, fEnergyLeft=16'h3333, fChosenCH=25, iAmDestination=1.
- Same packet with destID=16'hFFFF and then with destID=16'd9 -> en both times; iAmDestination=0 both times; the fields are re-latched.
- Q packet with srcID=16'd7 (own echo), then a packet of type 4'h5 -> no en, no HB_Reset; outputs hold their previous values. With RX_PKT_STATS_EN defined, pktDropped=2.
- Q packet with rx_last on word 5, then a 10-word Q packet -> no en for either. A valid Q packet sent immediately after -> accepted normally. With RX_PKT_STATS_EN defined, pktMalformed=2.
- nrst asserted on word 4 of a Q packet, rx_valid held with no gaps -> outputs go to 0; the remaining words are parsed as a new packet. Word 4 = 16'h0c00 has type 0 and is discarded, so no en until the next valid packet.
